bench_rx: RTL and testbench
===========================

BENCH_RX -- requirements
Module: bench_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 16: data bits per serial word.
REQ-002 SHALL have parameter N_WORDS, default 4: words per frame following one trigger.
REQ-003 SHALL have parameter DELAY, default 8, legal range 1..255: clock edges from trigger detection to the first data-bit sample.
REQ-004 SHALL have port clk, input, 1 bit: single clock, 357 MHz nominal; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port trig, input, 1 bit: frame trigger from the bench transmitter; rising edge starts a frame.
REQ-007 SHALL have port data_in, input, 1 bit: serial data from the transmitter, MSB first.
REQ-008 SHALL have port word_out, output, WORD_W bits: most recently completed word.
REQ-009 SHALL have port word_valid, output, 1 bit: one-cycle pulse qualifying word_out.
REQ-010 SHALL have port word_idx, output, clog2(N_WORDS) bits: index (0..N_WORDS-1) of word_out.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last word_valid of a frame.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-013 SHALL have port miss_cnt, output, 8 bits: saturating count of triggers ignored while busy.

Function
REQ-014 SHALL register trig once (trig_d); edge = trig & ~trig_d, evaluated on each clk edge E.
REQ-015 SHALL implement FSM states IDLE, WAIT, SHIFT.
REQ-016 IDLE -> WAIT on edge; delay counter loaded so that the first bit is sampled at edge E+DELAY.
REQ-017 WAIT -> SHIFT when the delay counter expires; no data sampled in WAIT.
REQ-018 In SHIFT, bit b of word k SHALL be sampled at edge E+DELAY+k*WORD_W+b, shifted in MSB first.
REQ-019 word_out, word_idx = k and word_valid SHALL be updated and asserted on the edge after the last bit of word k is sampled (latency 1 cycle).
REQ-020 After word N_WORDS-1, frame_done SHALL pulse with its word_valid; FSM returns to IDLE on the same edge.
REQ-021 busy SHALL be high exactly in WAIT and SHIFT, registered, i.e. from E+1 through the frame_done cycle.
REQ-022 An edge detected while busy SHALL NOT restart or alter the frame; miss_cnt increments, saturating at 255.
REQ-023 An edge on the same edge that the FSM returns to IDLE (frame_done cycle) SHALL count as a miss, not start a frame.
REQ-024 word_out SHALL hold its value between word_valid pulses.
REQ-025 Bit and word counters SHALL be clog2-sized; no wrap beyond WORD_W-1 or N_WORDS-1.

Reset
REQ-026 On rst: FSM = IDLE, word_out = 0, word_valid = 0, word_idx = 0, frame_done = 0, busy = 0, miss_cnt = 0, shift register and counters = 0.
REQ-027 trig_d SHALL reset to 1, so a trig held high through reset release does not start a frame.
REQ-028 Reset mid-frame SHALL discard the partial word with no word_valid or frame_done pulse.

Structure
REQ-029 FSM state encoding and the default WORD_W/N_WORDS/DELAY constants SHALL live in a shared package, font5_bench_pkg.
REQ-030 The serial-to-parallel shift register and bit counter SHALL be one sub-module, bench_rx_shift, and the FSM stays in bench_rx.

Verification
REQ-031 Defaults, trig rises once, data_in drives words 0xA5C3, 0x0001, 0xFFFF, 0x8000 from E+8 -> four word_valid with word_idx 0..3 and matching values, frame_done with the 4th, busy low after.
REQ-032 Second trig edge 20 cycles into a frame -> frame unaffected, miss_cnt = 1; 300 such misses -> miss_cnt = 255.
REQ-033 rst asserted at bit 5 of word 2 -> no further word_valid or frame_done, all outputs 0; a new trig after release gives a clean frame.
REQ-034 trig held high across rst release -> no frame until trig goes low then high.
REQ-035 DELAY = 1, WORD_W = 4, N_WORDS = 1, back-to-back trig edges 5 cycles apart -> first frame completes, and the edge in the frame_done cycle counts as a miss.

Source files
------------

// File: rtl/font5_bench_pkg.sv
// Shared definitions for the bench serial receiver: FSM encoding,
// default frame geometry and a width helper for counters.
package font5_bench_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_N_WORDS = 4;
  localparam int DEF_DELAY   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } rx_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bench_rx_shift.sv
// Serial-to-parallel converter: shifts data_i in MSB first while
// sample_en_i is high and flags the sample that completes a word.
module bench_rx_shift
  import font5_bench_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en_i,
  input  logic              data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  localparam int              BIT_W    = clog2_min1(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // Next-state for shift register and bit position.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (sample_en_i) begin
      shift_d   = (shift_q << 1) | WORD_W'(data_i);
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  // State registers; the data path is reset too so no stale bits survive a reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign word_o      = shift_q;
  assign word_done_o = sample_en_i && (bit_cnt_q == LAST_BIT);

endmodule

// File: rtl/bench_rx.sv
// Bench frame receiver: a rising trig starts a frame of N_WORDS serial
// words whose first bit is sampled DELAY edges after the trigger edge.
module bench_rx
  import font5_bench_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int N_WORDS = DEF_N_WORDS,
  parameter int DELAY   = DEF_DELAY
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              trig,
  input  logic                              data_in,
  output logic [WORD_W-1:0]                 word_out,
  output logic                              word_valid,
  output logic [clog2_min1(N_WORDS)-1:0]    word_idx,
  output logic                              frame_done,
  output logic                              busy,
  output logic [7:0]                        miss_cnt
);

  localparam int               IDX_W     = clog2_min1(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(N_WORDS - 1);

  rx_state_e         state_q;
  logic              trig_q;
  logic [7:0]        dly_q;
  logic [IDX_W-1:0]  word_cnt_q;
  logic              pend_q;
  logic              pend_last_q;
  logic [IDX_W-1:0]  pend_idx_q;
  logic [WORD_W-1:0] word_out_q;
  logic              word_valid_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic              frame_done_q;
  logic              busy_q;
  logic [7:0]        miss_q;

  logic              trig_edge;
  logic              sample_en;
  logic              word_done;
  logic [WORD_W-1:0] shift_word;

  assign trig_edge = trig & ~trig_q;

  // Sampling starts on the edge the delay expires and stops once the last
  // word of the frame has been captured (its output pulse is still pending).
  assign sample_en = ((state_q == ST_WAIT) && (dly_q == 8'd0)) ||
                     ((state_q == ST_SHIFT) && !(pend_q && pend_last_q));

  bench_rx_shift #(
    .WORD_W (WORD_W)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .sample_en_i (sample_en),
    .data_i      (data_in),
    .word_o      (shift_word),
    .word_done_o (word_done)
  );

  // Frame FSM with registered outputs; a completed word is published one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trig_q       <= 1'b1;  // a trig held high through reset is not an edge
      dly_q        <= '0;
      word_cnt_q   <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_idx_q   <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      word_idx_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      miss_q       <= '0;
    end else begin
      trig_q       <= trig;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= (state_q != ST_IDLE);

      // Any edge outside IDLE, including the frame_done edge, is a miss.
      if (trig_edge && (state_q != ST_IDLE) && (miss_q != 8'hFF))
        miss_q <= miss_q + 8'd1;

      case (state_q)
        ST_IDLE: begin
          if (trig_edge) begin
            state_q    <= ST_WAIT;
            dly_q      <= 8'(DELAY - 1);
            word_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (dly_q == 8'd0) state_q <= ST_SHIFT;
          else               dly_q   <= dly_q - 8'd1;
        end
        ST_SHIFT: begin
          if (pend_q && pend_last_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (word_done) begin
        pend_q      <= 1'b1;
        pend_idx_q  <= word_cnt_q;
        pend_last_q <= (word_cnt_q == LAST_WORD);
        word_cnt_q  <= (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + IDX_W'(1);
      end else begin
        pend_q <= 1'b0;
      end

      if (pend_q) begin
        word_out_q   <= shift_word;
        word_valid_q <= 1'b1;
        word_idx_q   <= pend_idx_q;
        frame_done_q <= pend_last_q;
      end
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_idx   = word_idx_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_bench_rx.sv
// Self-checking bench for bench_rx: default-geometry instance plus a
// small DELAY=1 / WORD_W=4 / N_WORDS=1 instance for back-to-back triggers.
module tb_bench_rx;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, trig, data_in;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic [1:0]    word_idx;
  logic          frame_done, busy;
  logic [7:0]    miss_cnt;

  logic          trig_s, data_s;
  logic [SW-1:0] word_out_s;
  logic          valid_s;
  logic [0:0]    idx_s;
  logic          done_s, busy_s;
  logic [7:0]    miss_s;

  bench_rx dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .data_in    (data_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .miss_cnt   (miss_cnt)
  );

  bench_rx #(.WORD_W(SW), .N_WORDS(1), .DELAY(1)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig_s),
    .data_in    (data_s),
    .word_out   (word_out_s),
    .word_valid (valid_s),
    .word_idx   (idx_s),
    .frame_done (done_s),
    .busy       (busy_s),
    .miss_cnt   (miss_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: frame contents, trigger-pulse times within a frame,
  // last published word and expected miss count.
  logic [W-1:0] frame_words [N];
  int           miss_at [$];
  logic [W-1:0] exp_word;
  int           exp_miss;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one frame on the default instance and checks every cycle.
  // Edge E is rel=0; bit b of word k is driven for edge D+k*W+b; word k is
  // expected one edge after its last bit. rst_rel >= 0 pulses rst at that edge.
  task automatic run_frame(input int rst_rel);
    int  t_done;
    int  s, k;
    bit  dead, exp_v, exp_fd, exp_busy, pulse;
    t_done = D + N * W;
    dead   = 1'b0;
    @(negedge clk);
    trig    = 1'b1;
    data_in = 1'($urandom);
    for (int rel = 0; rel <= t_done + 2; rel++) begin
      pulse = 1'b0;
      if (rel > 0) begin
        foreach (miss_at[i]) if (miss_at[i] == rel) pulse = 1'b1;
        trig = pulse;
        s = rel - D;
        if (s >= 0 && s < N * W) data_in = frame_words[s / W][W - 1 - (s % W)];
        else                     data_in = 1'($urandom);
        rst = (rel == rst_rel);
      end
      @(posedge clk);
      @(negedge clk);
      if (rel == rst_rel) begin
        dead     = 1'b1;
        exp_word = '0;
        exp_miss = 0;
      end
      if (!dead && pulse && rel >= 1 && rel <= t_done && exp_miss < 255) exp_miss++;
      k      = (rel - D) / W - 1;
      exp_v  = !dead && (rel >= D + W) && ((rel - D) % W == 0) && (k < N);
      exp_fd = exp_v && (k == N - 1);
      exp_busy = !dead && (rel >= 1) && (rel <= t_done);
      if (exp_v) exp_word = frame_words[k];

      n_checks++;
      if (word_valid !== exp_v) begin
        n_errors++;
        $display("FAIL word_valid rel=%0d got=%b exp=%b", rel, word_valid, exp_v);
      end
      n_checks++;
      if (frame_done !== exp_fd) begin
        n_errors++;
        $display("FAIL frame_done rel=%0d got=%b exp=%b", rel, frame_done, exp_fd);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("FAIL busy rel=%0d got=%b exp=%b", rel, busy, exp_busy);
      end
      n_checks++;
      if (word_out !== exp_word) begin
        n_errors++;
        $display("FAIL word_out rel=%0d got=%h exp=%h", rel, word_out, exp_word);
      end
      n_checks++;
      if (miss_cnt !== 8'(exp_miss)) begin
        n_errors++;
        $display("FAIL miss_cnt rel=%0d got=%0d exp=%0d", rel, miss_cnt, exp_miss);
      end
      if (exp_v) begin
        n_checks++;
        if (word_idx !== 2'(k)) begin
          n_errors++;
          $display("FAIL word_idx rel=%0d got=%0d exp=%0d", rel, word_idx, k);
        end
      end
      if (dead) begin
        n_checks++;
        if (word_idx !== 2'd0) begin
          n_errors++;
          $display("FAIL word_idx_after_rst rel=%0d got=%0d exp=0", rel, word_idx);
        end
      end
    end
    rst  = 1'b0;
    trig = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 1'b1; data_in = 1'b0; trig_s = 1'b0; data_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({word_out, word_valid, word_idx, frame_done, busy, miss_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_state got out=%h v=%b idx=%0d fd=%b busy=%b miss=%0d exp all 0",
               word_out, word_valid, word_idx, frame_done, busy, miss_cnt);
    end
    n_checks++;
    if ({word_out_s, valid_s, idx_s, done_s, busy_s, miss_s} !== '0) begin
      n_errors++;
      $display("FAIL reset_state_small got out=%h v=%b busy=%b miss=%0d exp all 0",
               word_out_s, valid_s, busy_s, miss_s);
    end
    // trig stays high across reset release: must not start a frame.
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      data_in = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || word_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL trig_held_busy cycle=%0d got busy=%b v=%b exp 0 0", c, busy, word_valid);
      end
    end
    trig = 1'b0;
    @(posedge clk);
    exp_word = '0;
    exp_miss = 0;
  endtask

  task automatic test_frame();
    frame_words[0] = 16'hA5C3;
    frame_words[1] = 16'h0001;
    frame_words[2] = 16'hFFFF;
    frame_words[3] = 16'h8000;
    miss_at = {};
    run_frame(-1);
    for (int f = 0; f < 3; f++) begin
      foreach (frame_words[i]) frame_words[i] = W'($urandom);
      run_frame(-1);
    end
  endtask

  task automatic test_miss();
    foreach (frame_words[i]) frame_words[i] = W'($urandom);
    miss_at = {20};
    run_frame(-1);
    n_checks++;
    if (miss_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL single_miss got=%0d exp=1", miss_cnt);
    end
  endtask

  task automatic test_saturate();
    miss_at = {};
    for (int r = 2; r <= D + N * W; r += 2) miss_at.push_back(r);
    for (int f = 0; f < 9; f++) begin
      foreach (frame_words[i]) frame_words[i] = W'($urandom);
      run_frame(-1);
    end
    n_checks++;
    if (miss_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL miss_saturate got=%0d exp=255", miss_cnt);
    end
  endtask

  task automatic test_mid_reset();
    foreach (frame_words[i]) frame_words[i] = W'($urandom);
    miss_at = {30};
    run_frame(D + 2 * W + 5);
    foreach (frame_words[i]) frame_words[i] = W'($urandom);
    miss_at = {};
    run_frame(-1);
  endtask

  // Small instance: edge at rel 0, second edge at rel 5 lands on the
  // frame_done edge and must count as a miss; a later edge frames cleanly.
  task automatic test_back_to_back();
    logic [SW-1:0] w;
    int  last_rel;
    bit  exp_v, exp_busy;
    logic [SW-1:0] exp_w;
    int  exp_m;
    exp_w = '0;
    exp_m = 0;
    for (int pass = 0; pass < 2; pass++) begin
      w = SW'($urandom);
      last_rel = (pass == 0) ? 12 : 6;
      @(negedge clk);
      trig_s = 1'b1;
      data_s = 1'($urandom);
      for (int rel = 0; rel <= last_rel; rel++) begin
        if (rel > 0) begin
          trig_s = (pass == 0) && (rel == 5);
          data_s = (rel <= SW) ? w[SW - rel] : 1'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        exp_v    = (rel == 5);
        exp_busy = (rel >= 1) && (rel <= 5);
        if (pass == 0 && rel == 5) exp_m = 1;
        if (exp_v) exp_w = w;
        n_checks++;
        if (valid_s !== exp_v || done_s !== exp_v) begin
          n_errors++;
          $display("FAIL small_valid pass=%0d rel=%0d got v=%b fd=%b exp %b", pass, rel, valid_s, done_s, exp_v);
        end
        n_checks++;
        if (busy_s !== exp_busy) begin
          n_errors++;
          $display("FAIL small_busy pass=%0d rel=%0d got=%b exp=%b", pass, rel, busy_s, exp_busy);
        end
        n_checks++;
        if (word_out_s !== exp_w) begin
          n_errors++;
          $display("FAIL small_word pass=%0d rel=%0d got=%h exp=%h", pass, rel, word_out_s, exp_w);
        end
        n_checks++;
        if (miss_s !== 8'(exp_m)) begin
          n_errors++;
          $display("FAIL small_miss pass=%0d rel=%0d got=%0d exp=%0d", pass, rel, miss_s, exp_m);
        end
        if (exp_v) begin
          n_checks++;
          if (idx_s !== 1'b0) begin
            n_errors++;
            $display("FAIL small_idx pass=%0d got=%0d exp=0", pass, idx_s);
          end
        end
      end
      trig_s = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_miss();
    test_saturate();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
